pe8_arbiter: RTL
================

# pe8_arbiter

Eight-requester arbiter for a single shared resource. Grant selection uses the same priority order and index encoding as the team's 8-input priority encoder. The block holds a grant until the owner releases it or a hold timeout expires, then inserts one turnaround cycle before the next grant. It sits between the requesting units and the shared resource, and its encoded grant index drives the resource's select mux.

## Interface
- HOLD_MAX, default 16: maximum cycles a grant may be held; 0 disables the timeout.
- clk  input  1  clock; all flops update on the falling edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  8  request lines; req[k] is requester k, and req[7] has the highest fixed priority.
- gnt  output  8  one-hot grant; all zero when no grant is active.
- gnt_id  output  4  encoded grant: 0 = none, k+1 = requester k (so requester 7 gives 4'b1000).
- busy  output  1  high while in GRANT.
- timeout  output  1  one-cycle pulse when a grant is forcibly revoked.

## Operation
- States:
  - IDLE: no grant.
  - GRANT: one owner holds the resource.
  - GAP: one dead turnaround cycle.
- IDLE:
  - If eligible requests are non-zero, latch the winner, load the hold counter with 0, and go to GRANT.
  - Otherwise stay in IDLE.
- Eligible requests = req & ~mask.
- GRANT:
  - gnt and gnt_id are constant for the whole grant.
  - The counter increments once per clock.
  - Go to GAP on the edge where req[owner] is sampled low.
  - If HOLD_MAX != 0, also go to GAP on the edge where the counter equals HOLD_MAX-1 (timeout). In that case:
    - set mask[owner];
    - pulse timeout in the first GAP cycle.
  - If release and timeout occur on the same edge, it is a normal release: no mask, no pulse.
- GAP:
  - gnt = 0.
  - Next edge: go to GRANT with a new winner if eligible requests are non-zero, else go to IDLE.
  - GAP is never skipped.
- Mask:
  - mask[k] clears on any edge where req[k] is sampled low.
  - A timed-out requester must drop req for at least one cycle before it can win again.
- Winner selection (fixed priority): highest-indexed eligible request.
- Requests arriving mid-GRANT are ignored until GAP; no preemption.
- Counter width: $clog2(HOLD_MAX+1), minimum 1 bit. It saturates and never wraps.

## Timing
- Reset values: state = IDLE, gnt = 0, gnt_id = 0, busy = 0, timeout = 0, mask = 0, counter = 0.
- All outputs are registered; no combinational path from req to any output.
- Grant latency: req sampled high in IDLE at falling edge N → gnt valid after edge N (one cycle).
- Release: req[owner] low at edge N → gnt = 0 after edge N. The next grant, if any, appears after edge N+1.
- Timeout: with HOLD_MAX = H, gnt is high for exactly H cycles.
- Reset asserted mid-grant: gnt and outputs clear immediately (asynchronously); the state returns to IDLE.
- Reset deassertion is synchronized externally. The first grant can occur at the first falling edge after rst_n rises.

## Configuration
- PE8_ARB_ROUND_ROBIN_EN:
  - Defined: the block keeps a 3-bit last-owner pointer (reset value 7). Priority search starts at last_owner-1 and descends with wrap-around from 0 to 7, so the previous owner ranks lowest. The pointer updates on entry to GRANT.
  - Undefined: fixed priority, req[7] highest. No pointer register.
  - The mask, timeout, and GAP behaviour is identical in both builds.

## Structure
- Package pe8_arb_pkg:
  - NUM_REQ = 8, ID_W = 4;
  - state enum {IDLE, GRANT, GAP};
  - function to_id(k) returning k+1, with 0 reserved for "none".
- Sub-module pe8_prio_pick (combinational, one instance):
  - inputs: eligible request vector, start index;
  - outputs: valid, 3-bit winner.
  - Fixed-priority builds tie the start index to 7.
- Top level holds the FSM, hold counter, mask, output registers, and the optional RR pointer.

## Test plan
- Reset then req = 8'h00 for 10 cycles → gnt = 0, gnt_id = 0, busy = 0 throughout.
- req = 8'h81 at edge N → gnt = 8'h80 and gnt_id = 4'b1000 after N. Drop req[7] → gnt = 0 for one cycle, then gnt = 8'h01 and gnt_id = 4'b0001.
- HOLD_MAX = 4, req[3] held high → gnt = 8'h08 for exactly 4 cycles, timeout pulses once, req[3] is not re-granted until it toggles low then high.
- req = 8'hFF with PE8_ARB_ROUND_ROBIN_EN defined, each owner releasing after 1 cycle → grant order 6,5,4,3,2,1,0,7,6. Undefined → requester 7 wins every time.
- rst_n pulled low during GRANT with gnt = 8'h20 → gnt, gnt_id, and busy go to 0 without waiting for a clock edge. After rst_n releases, the first grant follows the normal one-cycle latency.
- req[2] dropped on the same edge the counter hits HOLD_MAX-1 → normal release: no timeout pulse, mask[2] stays 0.

Source files
------------

// File: rtl/pe8_arb_pkg.sv
// pe8_arb_pkg: shared constants, state encoding and grant-id helper for the
// pe8 arbiter slice.
//   NUM_REQ  number of requesters
//   IDX_W    width of a requester index
//   ID_W     width of the encoded grant id (0 = none, k+1 = requester k)
package pe8_arb_pkg;

    localparam int NUM_REQ = 8;
    localparam int IDX_W   = 3;
    localparam int ID_W    = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_e;

    // Encoded grant id; 0 is reserved for "no grant".
    function automatic logic [ID_W-1:0] to_id(input logic [IDX_W-1:0] k);
        return ID_W'({1'b0, k}) + ID_W'(1);
    endfunction

endpackage

// File: rtl/pe8_arbiter_if.sv
// pe8_arbiter_if: request/grant bundle between the requesting units and the
// arbiter.
//   req      requester -> arbiter, one line per requester (req[7] = top priority)
//   gnt      one-hot grant, zero when no grant is active
//   gnt_id   encoded grant (0 = none, k+1 = requester k), drives the resource mux
//   busy     high while a grant is held
//   timeout  one-cycle pulse when a grant is forcibly revoked
// Modports: master = requester side, slave = arbiter side.
interface pe8_arbiter_if;
    import pe8_arb_pkg::*;

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_id;
    logic               busy;
    logic               timeout;

    modport master (output req, input gnt, gnt_id, busy, timeout);
    modport slave  (input req, output gnt, gnt_id, busy, timeout);

endinterface

// File: rtl/pe8_prio_pick.sv
// pe8_prio_pick: combinational priority picker.
// Searches the eligible vector starting at 'start' and descending with
// wrap-around from 0 to NUM_REQ-1; the first set bit wins.
//   elig    eligible request vector
//   start   index with the highest priority for this search
//   valid   at least one eligible request
//   winner  index of the winning request (0 when !valid)
module pe8_prio_pick
    import pe8_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] elig,
    input  logic [IDX_W-1:0]   start,
    output logic               valid,
    output logic [IDX_W-1:0]   winner
);

    logic [IDX_W-1:0] idx;

    always_comb begin
        valid  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            // Index arithmetic is modulo NUM_REQ through the IDX_W truncation.
            idx = start - IDX_W'(i);
            if (!valid && elig[idx]) begin
                valid  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/pe8_arbiter.sv
// pe8_arbiter: eight-requester arbiter for one shared resource.
// A grant is held until the owner drops its request or the hold timeout
// expires; every grant is followed by exactly one dead GAP cycle. A requester
// that timed out is masked until it drops its request for a cycle.
// All flops update on the falling edge of clk; rst_n is asynchronous, active low.
//   clk, rst_n   clock and reset
//   bus (slave)  req in; gnt, gnt_id, busy, timeout out (all registered)
// Parameters:
//   HOLD_MAX     maximum grant length in cycles, 0 disables the timeout
// Build option:
//   PE8_ARB_ROUND_ROBIN_EN  defined: rotating priority with a last-owner
//                           pointer; undefined: fixed priority, req[7] highest
module pe8_arbiter
    import pe8_arb_pkg::*;
#(
    parameter int HOLD_MAX = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    pe8_arbiter_if.slave bus
);

    localparam int CNT_W = (HOLD_MAX < 1) ? 1 : $clog2(HOLD_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = '1;
    localparam logic [CNT_W-1:0] CNT_LAST = (HOLD_MAX > 0) ? CNT_W'(HOLD_MAX - 1) : '0;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_REQ-1:0] mask_q, mask_d;
    logic               to_d;

    logic [NUM_REQ-1:0] gnt_q;
    logic [ID_W-1:0]    gnt_id_q;
    logic               busy_q;
    logic               timeout_q;

    logic [NUM_REQ-1:0] elig;
    logic [IDX_W-1:0]   start;
    logic               pick_vld;
    logic [IDX_W-1:0]   pick_idx;
    logic               hold_expired;

    assign elig = bus.req & ~mask_q;

`ifdef PE8_ARB_ROUND_ROBIN_EN
    // Previous owner ranks lowest: the search begins just below it.
    logic [IDX_W-1:0] last_q, last_d;

    assign start = last_q - IDX_W'(1);

    always_comb begin
        last_d = last_q;
        if (state_q != GRANT && pick_vld) last_d = pick_idx;
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) last_q <= IDX_W'(NUM_REQ - 1);
        else        last_q <= last_d;
    end
`else
    assign start = IDX_W'(NUM_REQ - 1);
`endif

    pe8_prio_pick u_pick (
        .elig   (elig),
        .start  (start),
        .valid  (pick_vld),
        .winner (pick_idx)
    );

    assign hold_expired = (HOLD_MAX != 0) && (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        // A requester seen low is forgiven for any earlier timeout.
        mask_d  = mask_q & bus.req;
        to_d    = 1'b0;
        unique case (state_q)
            IDLE, GAP: begin
                if (pick_vld) begin
                    state_d = GRANT;
                    owner_d = pick_idx;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                if (cnt_q != CNT_SAT) cnt_d = cnt_q + CNT_W'(1);
                // Release wins over a coincident timeout: no mask, no pulse.
                if (!bus.req[owner_q]) begin
                    state_d = GAP;
                end else if (hold_expired) begin
                    state_d         = GAP;
                    mask_d[owner_q] = 1'b1;
                    to_d            = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            cnt_q     <= '0;
            mask_q    <= '0;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            cnt_q     <= cnt_d;
            mask_q    <= mask_d;
            // Outputs are registered from next-state so they hold for the grant.
            gnt_q     <= (state_d == GRANT) ? (NUM_REQ'(1) << owner_d) : '0;
            gnt_id_q  <= (state_d == GRANT) ? to_id(owner_d) : '0;
            busy_q    <= (state_d == GRANT);
            timeout_q <= to_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.gnt_id  = gnt_id_q;
    assign bus.busy    = busy_q;
    assign bus.timeout = timeout_q;

endmodule
